// File: rtl/key_stream_mux.sv
// key_stream_mux: registered NR_CH-to-1 stream selector, keyed or round-robin, valid/ready.
// Define MUX_LOCK_EN to add in_last and packet locking (grant held until end of packet).
module key_stream_mux #(
  parameter int NR_CH    = 4,
  parameter int DATA_LEN = 32,
  parameter int KEY_LEN  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [KEY_LEN-1:0]        sel_key,
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
`ifdef MUX_LOCK_EN
  input  logic [NR_CH-1:0]          in_last,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [KEY_LEN-1:0]        out_ch
);

  logic [KEY_LEN-1:0]  rr_ptr;
  logic [KEY_LEN-1:0]  grant_ch;
  logic [KEY_LEN-1:0]  grant_next;
  logic [KEY_LEN-1:0]  lock_ch;
  logic [DATA_LEN-1:0] grant_data;
  logic                grant_vld;
  logic                can_load;
  logic                xfer;
  logic                advance;
  logic                locked;

`ifdef MUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t        state, state_nxt;
  logic [KEY_LEN-1:0] lock_ch_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_ch_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lock_ch_nxt = lock_ch;
    case (state)
      IDLE:   if (xfer && mode && !in_last[grant_ch]) begin
                state_nxt   = LOCKED;
                lock_ch_nxt = grant_ch;
              end
      LOCKED: if (xfer && in_last[lock_ch]) state_nxt = IDLE;
    endcase
  end

  assign locked  = (state == LOCKED);
  // While locked grant_ch equals lock_ch, so this covers the beat that ends the packet.
  assign advance = xfer && (locked || mode) && in_last[grant_ch];
`else
  assign locked  = 1'b0;
  assign lock_ch = '0;
  assign advance = xfer && mode;
`endif

  // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    if (locked) begin
      grant_vld = in_valid[lock_ch];
      grant_ch  = lock_ch;
    end else if (!mode) begin
      for (int i = 0; i < NR_CH; i++) begin
        if (sel_key == KEY_LEN'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_ch  = KEY_LEN'(i);
        end
      end
    end else begin
      // Wrapped half first, then the half at/after rr_ptr overrides; downward scans pick the lowest.
      for (int i = NR_CH - 1; i >= 0; i--) begin
        if (in_valid[i] && KEY_LEN'(i) < rr_ptr) begin
          grant_vld = 1'b1;
          grant_ch  = KEY_LEN'(i);
        end
      end
      for (int i = NR_CH - 1; i >= 0; i--) begin
        if (in_valid[i] && KEY_LEN'(i) >= rr_ptr) begin
          grant_vld = 1'b1;
          grant_ch  = KEY_LEN'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NR_CH; i++) begin
      if (grant_ch == KEY_LEN'(i)) grant_data = in_data[i*DATA_LEN +: DATA_LEN];
    end
  end

  assign grant_next = (grant_ch == KEY_LEN'(NR_CH - 1)) ? '0 : grant_ch + 1'b1;
  assign can_load   = !out_valid || out_ready;
  assign xfer       = grant_vld && can_load;
  assign in_ready   = (xfer && rst_n) ? (NR_CH'(1) << grant_ch) : '0;

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (advance) rr_ptr <= grant_next;
    end
  end

endmodule

// File: tb/tb_key_stream_mux.sv
// Scoreboard bench for key_stream_mux: directed stimulus pushes hand-computed beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_key_stream_mux;
  localparam int NR_CH    = 4;
  localparam int DATA_LEN = 32;
  localparam int KEY_LEN  = 2;

  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    logic [KEY_LEN-1:0]  ch;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      mode = 1'b0;
  logic                      out_ready = 1'b0;
  logic [KEY_LEN-1:0]        sel_key = '0;
  logic [NR_CH-1:0]          in_valid = '0;
  logic [NR_CH-1:0]          in_ready;
  logic [NR_CH*DATA_LEN-1:0] in_data = '0;
  logic                      out_valid;
  logic [DATA_LEN-1:0]       out_data;
  logic [KEY_LEN-1:0]        out_ch;

  // Second instance with NR_CH=3 so that sel_key=3 is an out-of-range key.
  logic                      mode3 = 1'b0;
  logic                      out_ready3 = 1'b1;
  logic [KEY_LEN-1:0]        sel_key3 = '0;
  logic [2:0]                in_valid3 = '0;
  logic [2:0]                in_ready3;
  logic [3*DATA_LEN-1:0]     in_data3 = '0;
  logic                      out_valid3;
  logic [DATA_LEN-1:0]       out_data3;
  logic [KEY_LEN-1:0]        out_ch3;
`ifdef MUX_LOCK_EN
  logic [NR_CH-1:0]          in_last = '0;
  logic [2:0]                in_last3 = '0;
`endif

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  key_stream_mux #(.NR_CH(NR_CH), .DATA_LEN(DATA_LEN), .KEY_LEN(KEY_LEN)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_key(sel_key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef MUX_LOCK_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  key_stream_mux #(.NR_CH(3), .DATA_LEN(DATA_LEN), .KEY_LEN(KEY_LEN)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel_key(sel_key3),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
`ifdef MUX_LOCK_EN
    .in_last(in_last3),
`endif
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_ch(out_ch3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_LEN-1:0] data, input logic [KEY_LEN-1:0] ch);
    exp_q.push_back(beat_t'{data: data, ch: ch});
  endtask

  task automatic set_data(input logic [DATA_LEN-1:0] base);
    for (int n = 0; n < NR_CH; n++) in_data[n*DATA_LEN +: DATA_LEN] = base | 32'(n);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got ch %0d data %h, expected no beat", out_ch, out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_ch", 32'(out_ch), 32'(e.ch));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with traffic offered: nothing may be granted.
    mode = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    set_data(32'hDEAD_0000);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    in_valid = '0;

    // Keyed select of channel 2.
    mode = 1'b0;
    sel_key = 2'd2;
    in_valid = 4'b1111;
    set_data(32'hA5A5_0000);
    #1;
    check("keyed_in_ready", 32'(in_ready), 32'h4);
    push(32'hA5A5_0002, 2'd2);
    tick();
    in_valid = '0;
    check("keyed_out_valid", 32'(out_valid), 32'h1);
    tick();
    check("keyed_valid_clears", 32'(out_valid), 32'h0);

    // Keyed channel not valid: no grant.
    sel_key = 2'd1;
    in_valid = 4'b1000;
    #1;
    check("keyed_idle_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("keyed_idle_out_valid", 32'(out_valid), 32'h0);
    in_valid = '0;

    // Three-channel instance: key 3 is out of range, key 2 is served.
    sel_key3 = 2'd3;
    in_valid3 = 3'b111;
    in_data3[2*DATA_LEN +: DATA_LEN] = 32'h6666_0002;
    #1;
    check("badkey_in_ready", 32'(in_ready3), 32'h0);
    tick();
    check("badkey_out_valid", 32'(out_valid3), 32'h0);
    sel_key3 = 2'd2;
    #1;
    check("nr3_in_ready", 32'(in_ready3), 32'h4);
    tick();
    in_valid3 = '0;
    check("nr3_out_valid", 32'(out_valid3), 32'h1);
    check("nr3_out_data", out_data3, 32'h6666_0002);
    check("nr3_out_ch", 32'(out_ch3), 32'h2);

    // Round-robin, all valid, 8 beats back to back.
    mode = 1'b1;
    in_valid = 4'b1111;
    set_data(32'hC0DE_0000);
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
      push(32'hC0DE_0000 | 32'(i % 4), KEY_LEN'(i % 4));
      tick();
      check("rr_out_valid", 32'(out_valid), 32'h1);
    end
    in_valid = '0;
    tick();

    // Backpressure: hold a beat for 5 cycles while inputs and mode change.
    out_ready = 1'b0;
    in_valid = 4'b0010;
    set_data(32'h1111_0000);
    #1;
    check("bp_first_in_ready", 32'(in_ready), 32'h2);
    push(32'h1111_0001, 2'd1);
    tick();
    set_data(32'h2222_0000);
    in_valid = 4'b1111;
    mode = 1'b0;
    sel_key = 2'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'h0);
      check("stall_out_data", out_data, 32'h1111_0001);
      check("stall_out_ch", 32'(out_ch), 32'h1);
      tick();
    end
    mode = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'h4);
    push(32'h2222_0002, 2'd2);
    tick();
    check("bp_no_bubble", 32'(out_valid), 32'h1);
    in_valid = '0;
    tick();

    // Keyed full throughput, then round-robin resumes from rr_ptr=3 and wraps.
    mode = 1'b0;
    in_valid = 4'b1111;
    set_data(32'h3333_0000);
    for (int i = 0; i < 3; i++) begin
      sel_key = KEY_LEN'((i + 3) % 4);
      #1;
      check("tput_in_ready", 32'(in_ready), 32'(1 << ((i + 3) % 4)));
      push(32'h3333_0000 | 32'((i + 3) % 4), KEY_LEN'((i + 3) % 4));
      tick();
    end
    mode = 1'b1;
    #1;
    check("rr_resume_in_ready", 32'(in_ready), 32'h8);
    push(32'h3333_0003, 2'd3);
    tick();
    check("rr_wrap_in_ready", 32'(in_ready), 32'h1);
    push(32'h3333_0000, 2'd0);
    tick();
    in_valid = '0;
    tick();

    // Async reset while a beat is held: it is discarded, rr_ptr returns to 0.
    out_ready = 1'b0;
    in_valid = 4'b1111;
    set_data(32'h4444_0000);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_out_ch", 32'(out_ch), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'h1);
    push(32'h4444_0000, 2'd0);
    tick();
    in_valid = '0;

`ifdef MUX_LOCK_EN
    // Packet lock: ch1 sends 3 beats while ch0 and ch2 wait, then ch2 is served.
    tick();
    mode = 1'b1;
    in_valid = 4'b0111;
    in_last = 4'b0101;
    set_data(32'h5555_0000);
    #1;
    check("lock_b0_in_ready", 32'(in_ready), 32'h2);
    push(32'h5555_0001, 2'd1);
    tick();
    mode = 1'b0;
    sel_key = 2'd0;
    #1;
    check("lock_b1_in_ready", 32'(in_ready), 32'h2);
    push(32'h5555_0001, 2'd1);
    tick();
    mode = 1'b1;
    in_last = 4'b0111;
    #1;
    check("lock_b2_in_ready", 32'(in_ready), 32'h2);
    push(32'h5555_0001, 2'd1);
    tick();
    check("unlock_in_ready", 32'(in_ready), 32'h4);
    push(32'h5555_0002, 2'd2);
    tick();
    in_valid = '0;
`endif

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
